// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared widths and types for the memory-port arbiter slice.
//   ADDR_W          : byte address width of the memory port
//   XLEN            : data word width
//   MEM_ARB_MAX_REQ : largest requester count the arbiter accepts
//   mem_cmd_t       : forwarded command bundle (we/addr/wdata)
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int ADDR_W          = 16;
    localparam int XLEN            = 32;
    localparam int MEM_ARB_MAX_REQ = 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_rr_pick
// Combinational round-robin picker: returns the first set request found when
// scanning from i_ptr upward and wrapping past NUM_REQ-1 back to 0.
//   i_req     : request vector
//   i_ptr     : highest-priority index for this pick
//   o_gnt     : winning index (i_ptr when nothing requests)
//   o_any_req : at least one request is set
// ----------------------------------------------------------------------------
module mem_port_arbiter_rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GNT_W-1:0]   i_ptr,
    output logic [GNT_W-1:0]   o_gnt,
    output logic               o_any_req
);

    int w_idx;

    // Scan from farthest to nearest so the nearest set request wins.
    always_comb begin
        o_gnt     = i_ptr;
        o_any_req = 1'b0;
        w_idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_gnt     = GNT_W'(w_idx);
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// Zero added latency; grant is locked while the downstream port stalls.
//   clk, rst_n                    : clock, async active-low reset
//   s_mem_req/we/addr/wdata       : per-requester commands (packed slices)
//   s_mem_rdata, s_mem_ready      : broadcast read data, one-hot completion
//   m_mem_req/we/addr/wdata       : forwarded command to the memory port
//   m_mem_rdata, m_mem_ready      : memory read data and completion
//   grant_id                      : index of the current grant
//   busy                          : grant locked by a stalled transaction
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        s_mem_req,
    input  logic [NUM_REQ-1:0]        s_mem_we,
    input  logic [NUM_REQ*ADDR_W-1:0] s_mem_addr,
    input  logic [NUM_REQ*XLEN-1:0]   s_mem_wdata,
    output logic [XLEN-1:0]           s_mem_rdata,
    output logic [NUM_REQ-1:0]        s_mem_ready,
    output logic                      m_mem_req,
    output logic                      m_mem_we,
    output logic [ADDR_W-1:0]         m_mem_addr,
    output logic [XLEN-1:0]           m_mem_wdata,
    input  logic [XLEN-1:0]           m_mem_rdata,
    input  logic                      m_mem_ready,
    output logic [GNT_W-1:0]          grant_id,
    output logic                      busy
);

    if (NUM_REQ < 2 || NUM_REQ > MEM_ARB_MAX_REQ) begin : g_bad_num_req
        $error("mem_port_arbiter: NUM_REQ out of range");
    end

    logic [GNT_W-1:0] r_rr_ptr;
    logic             r_lock;
    logic [GNT_W-1:0] r_lock_id;

    logic [GNT_W-1:0] w_pick;
    logic             w_any_req;
    logic [GNT_W-1:0] w_gnt;
    logic             w_sel_req;
    logic             w_active;
    mem_cmd_t         w_cmd;

    function automatic logic [GNT_W-1:0] rr_next(input logic [GNT_W-1:0] g);
        logic [GNT_W-1:0] n;
        n = (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
        return n;
    endfunction

    mem_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_pick (
        .i_req     (s_mem_req),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_pick),
        .o_any_req (w_any_req)
    );

    // A locked grant ignores the picker; if its owner drops req the
    // transaction is abandoned and nothing is forwarded this cycle.
    always_comb begin
        w_gnt     = r_lock ? r_lock_id : w_pick;
        w_sel_req = r_lock ? s_mem_req[r_lock_id] : w_any_req;
        w_active  = rst_n & w_sel_req;
        w_cmd     = '0;
        if (w_active) begin
            w_cmd.we    = s_mem_we[w_gnt];
            w_cmd.addr  = s_mem_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
            w_cmd.wdata = s_mem_wdata[int'(w_gnt)*XLEN +: XLEN];
        end
    end

    always_comb begin
        s_mem_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_mem_ready[i] = w_active & m_mem_ready & (int'(w_gnt) == i);
        end
    end

    assign m_mem_req   = w_active;
    assign m_mem_we    = w_cmd.we;
    assign m_mem_addr  = w_cmd.addr;
    assign m_mem_wdata = w_cmd.wdata;
    assign s_mem_rdata = m_mem_rdata;
    // The picker may point at a live request during reset; force index 0.
    assign grant_id    = rst_n ? w_gnt : '0;
    assign busy        = r_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_active && m_mem_ready) begin
            r_rr_ptr <= rr_next(w_gnt);
            r_lock   <= 1'b0;
        end else if (w_active) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_gnt;
        end else begin
            // Idle or abandoned: release any lock, keep priority pointer.
            r_lock <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int GW = $clog2(N);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          req = '0;
    logic [N-1:0]          we = '0;
    logic [N*ADDR_W-1:0]   addr = '0;
    logic [N*XLEN-1:0]     wdata = '0;
    logic [XLEN-1:0]       s_rdata;
    logic [N-1:0]          s_ready;
    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [XLEN-1:0]       m_wdata;
    logic [XLEN-1:0]       m_rdata;
    logic                  m_ready = 1'b1;
    logic [GW-1:0]         gid;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    // reference-model state
    int m_ptr     = 0;
    bit m_lock    = 0;
    int m_lock_id = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(N), .GNT_W(GW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_mem_req   (req),
        .s_mem_we    (we),
        .s_mem_addr  (addr),
        .s_mem_wdata (wdata),
        .s_mem_rdata (s_rdata),
        .s_mem_ready (s_ready),
        .m_mem_req   (m_req),
        .m_mem_we    (m_we),
        .m_mem_addr  (m_addr),
        .m_mem_wdata (m_wdata),
        .m_mem_rdata (m_rdata),
        .m_mem_ready (m_ready),
        .grant_id    (gid),
        .busy        (busy)
    );

    // Behavioural memory behind the port: combinational read, write on handshake.
    logic [XLEN-1:0] mem [0:255];

    function automatic logic [7:0] midx(input logic [ADDR_W-1:0] a);
        return {a[13:12], a[7:2]};
    endfunction

    assign m_rdata = mem[midx(m_addr)];

    always @(posedge clk) begin
        if (m_req && m_ready && m_we) mem[midx(m_addr)] <= m_wdata;
    end

    // Expected grant from the round-robin rule: locked owner, else the first
    // requester at or after the pointer (modulo N), else the pointer itself.
    function automatic int exp_gnt(input logic [N-1:0] r);
        if (m_lock) return m_lock_id;
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return m_ptr;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [XLEN-1:0] d);
        req[i] = 1'b1;
        we[i]  = w;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*XLEN +: XLEN]    = d;
    endtask

    task automatic clr_req(input int i);
        req[i] = 1'b0;
        we[i]  = 1'b0;
        addr[i*ADDR_W +: ADDR_W] = '0;
        wdata[i*XLEN +: XLEN]    = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        m_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        m_ptr = 0; m_lock = 0; m_lock_id = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 1'b1, 16'h0100, 32'hDEAD_BEEF);
        set_req(1, 1'b1, 16'h0104, 32'h0BAD_F00D);
        m_ready = 1'b1;
        @(negedge clk);
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rst_m_req got=%b want=0", m_req); end
        total++; if (s_ready !== '0) begin bad++; $display("FAIL rst_s_ready got=%b want=000", s_ready); end
        total++; if (gid !== '0) begin bad++; $display("FAIL rst_grant got=%0d want=0", gid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (m_we !== 1'b0) begin bad++; $display("FAIL rst_m_we got=%b want=0", m_we); end
        total++; if (m_addr !== '0) begin bad++; $display("FAIL rst_m_addr got=%h want=0", m_addr); end
        total++; if (m_wdata !== '0) begin bad++; $display("FAIL rst_m_wdata got=%h want=0", m_wdata); end
        req = '0; we = '0; addr = '0; wdata = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 1'b1, 16'h0100, 32'h1234_5678);
        @(negedge clk);
        total++; if (s_ready !== 3'b001) begin bad++; $display("FAIL single_wr_ready got=%b want=001", s_ready); end
        total++; if (m_we !== 1'b1 || m_addr !== 16'h0100) begin bad++; $display("FAIL single_wr_cmd got=%b/%h want=1/0100", m_we, m_addr); end
        total++; if (m_wdata !== 32'h1234_5678) begin bad++; $display("FAIL single_wr_data got=%h want=12345678", m_wdata); end
        next_cycle();
        set_req(0, 1'b0, 16'h0100, 32'h0);
        @(negedge clk);
        total++; if (s_ready !== 3'b001) begin bad++; $display("FAIL single_rd_ready got=%b want=001", s_ready); end
        total++; if (s_rdata !== 32'h1234_5678) begin bad++; $display("FAIL single_rd_data got=%h want=12345678", s_rdata); end
        next_cycle();
        clr_req(0);
        @(negedge clk);
        total++; if (m_req !== 1'b0 || s_ready !== '0) begin bad++; $display("FAIL single_idle got=%b/%b want=0/000", m_req, s_ready); end
    endtask

    task automatic test_rr();
        int k0, k1, c0, c1;
        k0 = 0; k1 = 0; c0 = 0; c1 = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_req(0, 1'b1, 16'(32'h1000 + 4*k0), 32'hA000_0000 + 32'(k0));
            set_req(1, 1'b1, 16'(32'h2000 + 4*k1), 32'hB000_0000 + 32'(k1));
            @(negedge clk);
            total++; if (gid !== GW'(c % 2)) begin bad++; $display("FAIL rr_grant c=%0d got=%0d want=%0d", c, gid, c % 2); end
            c0 += int'(s_ready[0]);
            c1 += int'(s_ready[1]);
            if (c % 2 == 0) k0++; else k1++;
            next_cycle();
        end
        clr_req(0); clr_req(1);
        total++; if (c0 != 4) begin bad++; $display("FAIL rr_count0 got=%0d want=4", c0); end
        total++; if (c1 != 4) begin bad++; $display("FAIL rr_count1 got=%0d want=4", c1); end
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 2; r++) begin
                set_req(0, 1'b0, 16'((r == 0 ? 32'h1000 : 32'h2000) + 4*k), 32'h0);
                @(negedge clk);
                total++;
                if (s_ready !== 3'b001 || s_rdata !== ((r == 0 ? 32'hA000_0000 : 32'hB000_0000) + 32'(k))) begin
                    bad++;
                    $display("FAIL rr_readback r=%0d k=%0d got=%b/%h want=001/%h", r, k, s_ready, s_rdata,
                             (r == 0 ? 32'hA000_0000 : 32'hB000_0000) + 32'(k));
                end
                next_cycle();
            end
        end
        clr_req(0);
    endtask

    task automatic test_stall();
        do_reset();
        m_ready = 1'b0;
        set_req(0, 1'b0, 16'h0100, 32'h0);
        @(negedge clk);
        total++; if (gid !== 2'd0 || busy !== 1'b0 || m_req !== 1'b1 || s_ready !== '0) begin
            bad++; $display("FAIL stall_c1 got=g%0d/b%b/r%b/%b want=g0/b0/r1/000", gid, busy, m_req, s_ready); end
        next_cycle();
        set_req(1, 1'b1, 16'h0104, 32'h0000_0055);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            total++; if (gid !== 2'd0 || busy !== 1'b1 || s_ready !== '0) begin
                bad++; $display("FAIL stall_c%0d got=g%0d/b%b/%b want=g0/b1/000", c, gid, busy, s_ready); end
            next_cycle();
        end
        m_ready = 1'b1;
        @(negedge clk);
        total++; if (gid !== 2'd0 || busy !== 1'b1 || s_ready !== 3'b001) begin
            bad++; $display("FAIL stall_c4 got=g%0d/b%b/%b want=g0/b1/001", gid, busy, s_ready); end
        next_cycle();
        clr_req(0);
        @(negedge clk);
        total++; if (gid !== 2'd1 || busy !== 1'b0 || s_ready !== 3'b010) begin
            bad++; $display("FAIL stall_c5 got=g%0d/b%b/%b want=g1/b0/010", gid, busy, s_ready); end
        next_cycle();
        clr_req(1);
        @(negedge clk);
        total++; if (busy !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL stall_c6 got=b%b/r%b want=b0/r0", busy, m_req); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(2, 1'b1, 16'h0200, 32'h0000_00C2);
        @(negedge clk);
        total++; if (gid !== 2'd2 || s_ready !== 3'b100) begin bad++; $display("FAIL wrap_first got=g%0d/%b want=g2/100", gid, s_ready); end
        next_cycle();
        set_req(0, 1'b1, 16'h0204, 32'h0000_00C0);
        set_req(2, 1'b1, 16'h0208, 32'h0000_00C3);
        @(negedge clk);
        total++; if (gid !== 2'd0 || s_ready !== 3'b001) begin bad++; $display("FAIL wrap_second got=g%0d/%b want=g0/001", gid, s_ready); end
        next_cycle();
        clr_req(0);
        @(negedge clk);
        total++; if (gid !== 2'd2 || s_ready !== 3'b100) begin bad++; $display("FAIL wrap_third got=g%0d/%b want=g2/100", gid, s_ready); end
        next_cycle();
        clr_req(2);
    endtask

    task automatic test_reset_stall();
        do_reset();
        m_ready = 1'b0;
        set_req(0, 1'b0, 16'h0100, 32'h0);
        next_cycle();
        set_req(1, 1'b1, 16'h0104, 32'h0000_0066);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rststall_pre got=b%b want=b1", busy); end
        #1;
        rst_n = 1'b0;
        m_ready = 1'b1;
        #1;
        total++; if (m_req !== 1'b0 || busy !== 1'b0 || gid !== '0 || s_ready !== '0 || m_addr !== '0) begin
            bad++; $display("FAIL rststall_async got=r%b/b%b/g%0d/%b/%h want=r0/b0/g0/000/0000", m_req, busy, gid, s_ready, m_addr); end
        next_cycle();
        clr_req(0); clr_req(1);
        rst_n = 1'b1;
        set_req(1, 1'b1, 16'h3000, 32'hBBBB_BBBB);
        @(negedge clk);
        total++; if (gid !== 2'd1 || s_ready !== 3'b010) begin bad++; $display("FAIL rststall_wr got=g%0d/%b want=g1/010", gid, s_ready); end
        next_cycle();
        set_req(1, 1'b0, 16'h3000, 32'h0);
        @(negedge clk);
        total++; if (s_ready !== 3'b010 || s_rdata !== 32'hBBBB_BBBB) begin
            bad++; $display("FAIL rststall_rd got=%b/%h want=010/bbbbbbbb", s_ready, s_rdata); end
        next_cycle();
        clr_req(1);
    endtask

    task automatic test_abandon();
        do_reset();
        set_req(0, 1'b0, 16'h0100, 32'h0);
        next_cycle();
        set_req(1, 1'b0, 16'h0104, 32'h0);
        m_ready = 1'b0;
        @(negedge clk);
        total++; if (gid !== 2'd1 || busy !== 1'b0) begin bad++; $display("FAIL aband_lockon got=g%0d/b%b want=g1/b0", gid, busy); end
        next_cycle();
        clr_req(1);
        m_ready = 1'b1;
        @(negedge clk);
        total++; if (m_req !== 1'b0 || busy !== 1'b1 || s_ready !== '0) begin
            bad++; $display("FAIL aband_drop got=r%b/b%b/%b want=r0/b1/000", m_req, busy, s_ready); end
        next_cycle();
        @(negedge clk);
        total++; if (busy !== 1'b0 || gid !== 2'd0 || s_ready !== 3'b001) begin
            bad++; $display("FAIL aband_after got=b%b/g%0d/%b want=b0/g0/001", busy, gid, s_ready); end
        next_cycle();
        clr_req(0);
    endtask

    task automatic test_random();
        bit                pend  [N];
        logic              pwe   [N];
        logic [ADDR_W-1:0] paddr [N];
        logic [XLEN-1:0]   pdat  [N];
        int                waits [N];
        int                g;
        logic              ereq;
        logic [N-1:0]      erdy;
        do_reset();
        for (int i = 0; i < N; i++) begin pend[i] = 0; waits[i] = 0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1;
                    pwe[i]   = 1'($urandom_range(0, 1));
                    paddr[i] = 16'(32'h0400 + 4 * $urandom_range(0, 15));
                    pdat[i]  = $urandom;
                    waits[i] = 0;
                end
                if (pend[i]) set_req(i, pwe[i], paddr[i], pdat[i]);
                else clr_req(i);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            g    = exp_gnt(req);
            ereq = pend[g];
            erdy = '0;
            if (ereq && m_ready) erdy[g] = 1'b1;
            @(negedge clk);
            total++; if (gid !== GW'(g)) begin bad++; $display("FAIL rand_grant cyc=%0d got=%0d want=%0d", cyc, gid, g); end
            total++; if (m_req !== ereq) begin bad++; $display("FAIL rand_m_req cyc=%0d got=%b want=%b", cyc, m_req, ereq); end
            total++; if (s_ready !== erdy) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, s_ready, erdy); end
            total++; if (busy !== m_lock) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, busy, m_lock); end
            if (ereq) begin
                total++;
                if (m_we !== pwe[g] || m_addr !== paddr[g] || m_wdata !== pdat[g]) begin
                    bad++; $display("FAIL rand_fwd cyc=%0d got=%b/%h/%h want=%b/%h/%h", cyc, m_we, m_addr, m_wdata, pwe[g], paddr[g], pdat[g]);
                end
            end
            // Fairness: a waiting requester sees at most N-1 other completions.
            if (s_ready != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (pend[i] && !s_ready[i]) begin
                        waits[i]++;
                        total++;
                        if (waits[i] > N - 1) begin bad++; $display("FAIL rand_fair cyc=%0d req=%0d got=%0d want<=%0d", cyc, i, waits[i], N - 1); end
                    end
                end
            end
            if (ereq && m_ready) begin
                pend[g] = 0;
                m_ptr   = (g + 1) % N;
                m_lock  = 0;
            end else if (ereq) begin
                m_lock    = 1;
                m_lock_id = g;
            end else begin
                m_lock = 0;
            end
            next_cycle();
        end
        req = '0; we = '0; addr = '0; wdata = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_stall();
        test_wrap();
        test_reset_stall();
        test_abandon();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
